// File: rtl/sram_port_arbiter.sv
// Round-robin N-port front end for one asynchronous SRAM bank with programmable wait states.
// Optional macro SRAM_ARB_PORT0_PRIO_EN gives port 0 strict priority over the round-robin ports.
module sram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic [ADDR_WIDTH-1:0]             io_sram_addr,
  output logic [DATA_WIDTH-1:0]             io_sram_din,
  input  logic [DATA_WIDTH-1:0]             io_sram_dout,
  output logic                              io_sram_en,
  output logic                              io_sram_re,
  output logic                              io_sram_we,
  output logic [DATA_WIDTH/8-1:0]           io_sram_wmask
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PTR_W-1:0]       r_last_grant, r_owner, w_grant;
  logic                   w_grant_vld, w_upd_ptr, w_accept;
  logic [3:0]             r_wait_cnt;
  logic                   r_active, r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_din, r_rdata;
  logic [MASK_W-1:0]      r_wmask;
  logic [NUM_PORTS-1:0]   r_resp_valid;

  // Scan from the port after the last grant, wrapping at NUM_PORTS-1.
  always_comb begin : arb
    logic [PTR_W-1:0] v_idx;
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_upd_ptr   = 1'b1;
    v_idx       = r_last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v_idx = (v_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : v_idx + PTR_W'(1);
      if (!w_grant_vld && req_valid[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = v_idx;
      end
    end
`ifdef SRAM_ARB_PORT0_PRIO_EN
    // Fetch port overrides the rotation and leaves the pointer untouched.
    if (req_valid[0]) begin
      w_grant     = '0;
      w_grant_vld = 1'b1;
      w_upd_ptr   = 1'b0;
    end
`endif
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_vld;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE:   if (w_grant_vld) w_state_nxt = S_ACCESS;
      S_ACCESS: if (r_wait_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    for (int i = 0; i < NUM_PORTS; i++)
      req_ready[i] = w_accept && !reset && (w_grant == PTR_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= PTR_W'(NUM_PORTS - 1);
      r_owner      <= '0;
      r_wait_cnt   <= '0;
      r_active     <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_wmask      <= '0;
      r_rdata      <= '0;
      r_resp_valid <= '0;
    end else begin
      if (w_accept) begin
        r_owner    <= w_grant;
        r_we       <= req_we[w_grant];
        r_addr     <= req_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
        r_din      <= req_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
        r_wmask    <= req_wmask[w_grant*MASK_W +: MASK_W];
        r_wait_cnt <= req_we[w_grant] ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
        r_active   <= 1'b1;
        if (w_upd_ptr) r_last_grant <= w_grant;
      end
      if (r_state == S_ACCESS) begin
        if (r_wait_cnt == 4'd0) begin
          r_active <= 1'b0;
          if (!r_we) r_rdata <= io_sram_dout;
          for (int i = 0; i < NUM_PORTS; i++)
            r_resp_valid[i] <= (r_owner == PTR_W'(i));
        end else begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
        end
      end
      if (r_state == S_RESP) r_resp_valid <= '0;
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_rdata;
  assign io_sram_en    = r_active;
  assign io_sram_re    = r_active && !r_we;
  assign io_sram_we    = r_active && r_we;
  assign io_sram_addr  = r_addr;
  assign io_sram_din   = r_din;
  assign io_sram_wmask = r_wmask;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-timeline model checked every cycle, plus directed cases.
// Honours SRAM_ARB_PORT0_PRIO_EN when the design is built with it.
module tb_sram_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int RW = 1;
  localparam int WW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid = '0;
  logic [NP-1:0]    req_we    = '0;
  logic [NP*AW-1:0] req_addr  = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP*MW-1:0] req_wmask = '0;
  logic [NP-1:0]    req_ready, resp_valid;
  logic [DW-1:0]    resp_rdata, io_sram_din, io_sram_dout;
  logic [AW-1:0]    io_sram_addr;
  logic             io_sram_en, io_sram_re, io_sram_we;
  logic [MW-1:0]    io_sram_wmask;

  sram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .io_sram_addr(io_sram_addr),
    .io_sram_din(io_sram_din), .io_sram_dout(io_sram_dout), .io_sram_en(io_sram_en),
    .io_sram_re(io_sram_re), .io_sram_we(io_sram_we), .io_sram_wmask(io_sram_wmask));

  // Single-port, zero-wait instance sharing the same SRAM contents (read only).
  logic          p1_valid = 1'b0;
  logic [AW-1:0] p1_addr  = '0;
  logic          p1_ready, p1_resp, p1_en, p1_re, p1_we;
  logic [DW-1:0] p1_rdata, p1_din, p1_dout;
  logic [AW-1:0] p1_sram_addr;
  logic [MW-1:0] p1_wmask;

  sram_port_arbiter #(.NUM_PORTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .READ_WAIT(0), .WRITE_WAIT(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(p1_valid), .req_ready(p1_ready),
    .req_we(1'b0), .req_addr(p1_addr), .req_wdata({DW{1'b0}}), .req_wmask({MW{1'b0}}),
    .resp_valid(p1_resp), .resp_rdata(p1_rdata), .io_sram_addr(p1_sram_addr),
    .io_sram_din(p1_din), .io_sram_dout(p1_dout), .io_sram_en(p1_en),
    .io_sram_re(p1_re), .io_sram_we(p1_we), .io_sram_wmask(p1_wmask));

  logic [DW-1:0] sram_mem [0:255];
  logic [DW-1:0] ref_mem  [0:255];
  assign io_sram_dout = sram_mem[io_sram_addr];
  assign p1_dout      = sram_mem[p1_sram_addr];

  always @(posedge clk)
    if (io_sram_en && io_sram_we)
      for (int b = 0; b < MW; b++)
        if (io_sram_wmask[b]) sram_mem[io_sram_addr][8*b +: 8] <= io_sram_din[8*b +: 8];

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 4)  return 32'hAABBCCDD;
    return {24'hC0FFEE, 8'(i)};
  endfunction

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: one transaction at a time, located on a cycle timeline.
  int            cyc = 0;
  bit            chk_en = 1'b0;
  bit            busy = 1'b0;
  int            t_acc = 0, cur_p = 0, cur_w = 0, last = NP - 1;
  bit            cur_we = 1'b0;
  logic [AW-1:0] cur_a = '0;
  logic [DW-1:0] cur_d = '0;
  logic [MW-1:0] cur_m = '0;
  logic [DW-1:0] exp_rdata = '0;

  function automatic int pick();
`ifdef SRAM_ARB_PORT0_PRIO_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 1; k <= NP; k++)
      if (req_valid[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [NP-1:0] e_rdy, e_resp;
    bit            e_act;
    int            g;
    cyc++;
    e_act  = busy && (cyc >= t_acc + 1) && (cyc <= t_acc + 1 + cur_w);
    e_resp = '0;
    if (busy && cyc == t_acc + 2 + cur_w) e_resp[cur_p] = 1'b1;
    g = (!busy && !reset) ? pick() : -1;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    if (chk_en) begin
      chk("req_ready", req_ready, e_rdy);
      chk("resp_valid", resp_valid, e_resp);
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("io_sram_en", io_sram_en, e_act);
      chk("io_sram_re", io_sram_re, e_act && !cur_we);
      chk("io_sram_we", io_sram_we, e_act && cur_we);
      if (e_act) begin
        chk("io_sram_addr", io_sram_addr, cur_a);
        chk("io_sram_wmask", io_sram_wmask, cur_m);
        if (cur_we) chk("io_sram_din", io_sram_din, cur_d);
      end
    end
    if (e_act && cur_we)
      for (int b = 0; b < MW; b++)
        if (cur_m[b]) ref_mem[cur_a][8*b +: 8] = cur_d[8*b +: 8];
    if (busy && !cur_we && cyc == t_acc + 1 + cur_w) exp_rdata = ref_mem[cur_a];
    if (busy && cyc == t_acc + 2 + cur_w) busy = 1'b0;
    if (g >= 0) begin
      busy   = 1'b1;
      t_acc  = cyc;
      cur_p  = g;
      cur_we = req_we[g];
      cur_a  = req_addr[g*AW +: AW];
      cur_d  = req_wdata[g*DW +: DW];
      cur_m  = req_wmask[g*MW +: MW];
      cur_w  = cur_we ? WW : RW;
`ifdef SRAM_ARB_PORT0_PRIO_EN
      if (g != 0) last = g;
`else
      last = g;
`endif
    end
    if (reset) begin
      busy      = 1'b0;
      last      = NP - 1;
      exp_rdata = '0;
    end
  end

  task automatic do_txn(input int p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m,
                        output int acc, output int rsp, output int nact, output logic [DW-1:0] rd);
    acc = -1; rsp = -1; nact = 0; rd = '0;
    req_we[p] = we;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_wmask[p*MW +: MW] = m;
    req_valid[p] = 1'b1;
    for (int k = 0; k < 20 && rsp < 0; k++) begin
      #2;
      if (req_ready[p] && acc < 0) acc = k;
      if (io_sram_en && (io_sram_we == we) && (io_sram_re == !we) && (io_sram_wmask == m)) nact++;
      if (resp_valid[p]) begin rsp = k; rd = resp_rdata; end
      @(posedge clk); #1;
      if (acc >= 0) req_valid[p] = 1'b0;
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic new_req(input int p);
    req_we[p] = 1'($urandom_range(0, 1));
    req_addr[p*AW +: AW]  = AW'($urandom_range(0, 15));
    req_wdata[p*DW +: DW] = $urandom;
    req_wmask[p*MW +: MW] = MW'($urandom_range(0, 15));
    req_valid[p] = 1'b1;
  endtask

  int            acc, rsp, nact, na, nr, n0;
  logic [DW-1:0] rd;
  int            pa[3], pr[3];
  logic [DW-1:0] pd[3];
  logic          acc_now;
  logic [NP-1:0] seen;
  int            order[$], exp_order[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] <= init_word(i);
      ref_mem[i]   = init_word(i);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("reset_ready", req_ready, 0);
    chk("reset_resp", resp_valid, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_strobes", {io_sram_en, io_sram_re, io_sram_we}, 0);
    chk("reset_addr_din_mask", {io_sram_addr, io_sram_din, io_sram_wmask}, 0);
    chk("reset_p1_outputs", {p1_ready, p1_resp, p1_en, p1_rdata}, 0);
    @(posedge clk); #1;

    // Single port, zero wait: three back-to-back reads.
    na = 0; nr = 0;
    p1_addr = 8'd1; p1_valid = 1'b1;
    for (int k = 0; k < 40 && nr < 3; k++) begin
      #2;
      acc_now = p1_ready;
      if (p1_ready && na < 3) begin pa[na] = k; na++; end
      if (p1_resp && nr < 3) begin pr[nr] = k; pd[nr] = p1_rdata; nr++; end
      @(posedge clk); #1;
      if (acc_now) begin
        if (na < 3) p1_addr = AW'(na + 1);
        else p1_valid = 1'b0;
      end
    end
    p1_valid = 1'b0;
    chk("zw_accepts", na, 3);
    chk("zw_resps", nr, 3);
    for (int i = 0; i < 3; i++) begin
      chk("zw_latency", pr[i] - pa[i], 2);
      chk("zw_rdata", pd[i], {24'hC0FFEE, 8'(i + 1)});
      if (i > 0) chk("zw_spacing", pa[i] - pa[i-1], 3);
    end

    // Single read of a preloaded word.
    do_txn(0, 1'b0, 8'h10, '0, '0, acc, rsp, nact, rd);
    chk("rd_accept_cycle", acc, 0);
    chk("rd_latency", rsp - acc, 3);
    chk("rd_active_cycles", nact, 2);
    chk("rd_data", rd, 32'hDEADBEEF);

    // Byte write through port 1.
    do_txn(1, 1'b1, 8'h04, 32'h11223344, 4'b0010, acc, rsp, nact, rd);
    chk("wr_accept_cycle", acc, 0);
    chk("wr_latency", rsp - acc, 4);
    chk("wr_active_cycles", nact, 3);
    chk("wr_resp_rdata_kept", rd, 32'hDEADBEEF);
    chk("wr_mem_word", sram_mem[4], 32'hAABB33DD);

    // Contention from a freshly reset pointer.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    order.delete();
    n0 = 0;
    for (int p = 0; p < NP; p++) begin
      req_we[p] = 1'b0;
      req_addr[p*AW +: AW] = AW'(32 + p);
      req_wmask[p*MW +: MW] = '0;
    end
`ifdef SRAM_ARB_PORT0_PRIO_EN
    exp_order = '{0, 0, 0, 1, 2};
    req_valid = 3'b111;
`else
    exp_order = '{0, 1, 0, 1};
    req_valid = 3'b011;
`endif
    for (int k = 0; k < 80 && order.size() < exp_order.size(); k++) begin
      #2;
      seen = req_ready;
      for (int p = 0; p < NP; p++) if (seen[p]) begin
        order.push_back(p);
        if (p == 0) n0++;
      end
      @(posedge clk); #1;
`ifdef SRAM_ARB_PORT0_PRIO_EN
      for (int p = 0; p < NP; p++)
        if (seen[p] && (p != 0 || n0 >= 3)) req_valid[p] = 1'b0;
`endif
    end
    req_valid = '0;
    chk("cont_grant_count", order.size(), exp_order.size());
    for (int i = 0; i < exp_order.size(); i++)
      chk("cont_grant_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    repeat (6) @(posedge clk);
    #1;

    // Reset during the second access cycle.
    acc = -1;
    req_we[1] = 1'b0;
    req_addr[1*AW +: AW] = 8'h30;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      #2;
      if (req_ready[1]) acc = k;
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("rst_mid_accepted", acc >= 0, 1);
    @(posedge clk); #1 reset = 1'b1;
    #2 chk("rst_mid_still_active", io_sram_en, 1);
    @(posedge clk); #1 reset = 1'b0;
    #2;
    chk("rst_mid_strobes", {io_sram_en, io_sram_re, io_sram_we}, 0);
    chk("rst_mid_addr_din_mask", {io_sram_addr, io_sram_din, io_sram_wmask}, 0);
    nr = 0;
    repeat (4) begin
      if (|resp_valid) nr++;
      @(posedge clk); #3;
    end
    chk("rst_mid_no_resp", nr, 0);
    @(posedge clk); #1;
    req_valid = 3'b111;
    #2 chk("rst_mid_next_grant", req_ready, 3'b001);
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic, with one reset pulse in the middle.
    for (int c = 0; c < 800; c++) begin
      #2;
      seen = req_ready;
      @(posedge clk); #1;
      reset = (c == 400);
      for (int p = 0; p < NP; p++) begin
        if (seen[p]) req_valid[p] = 1'b0;
        if (!req_valid[p]) begin
          if ($urandom_range(0, 2) == 0) new_req(p);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[p] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk("mem_contents", sram_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised N-port front end for one asynchronous SRAM bank. It replaces the fixed one-master-per-bank wiring with arbitrated sharing, for example instruction fetch and data accesses both reaching ext RAM.
- It sits between requesters (core ports, future DMA) and the SRAM-side signal set of the RAM wrapper: en/re/we/wmask/addr/din/dout.
- It provides round-robin arbitration, programmable access wait states, and a per-port response pulse.

Parameters:
- NUM_PORTS, 2, number of requesters (1..8).
- ADDR_WIDTH, 20, word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- READ_WAIT, 1, extra cycles the SRAM signals are held for a read (0..15).
- WRITE_WAIT, 1, extra cycles the SRAM signals are held for a write (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port accept; one-hot, one-cycle pulse.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened; port i is slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- req_wmask  in  NUM_PORTS*DATA_WIDTH/8  flattened byte-enable mask; active-high.
- resp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port; issued for both reads and writes.
- resp_rdata  out  DATA_WIDTH  read data; meaningful when any resp_valid bit is high.
- io_sram_addr  out  ADDR_WIDTH  SRAM address.
- io_sram_din  out  DATA_WIDTH  SRAM write data.
- io_sram_dout  in  DATA_WIDTH  SRAM read data.
- io_sram_en  out  1  chip enable.
- io_sram_re  out  1  read enable.
- io_sram_we  out  1  write enable.
- io_sram_wmask  out  DATA_WIDTH/8  byte mask.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Round-robin pointer last_grant = NUM_PORTS-1, so port 0 wins first.
  - Wait counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid port scanning from last_grant+1 (mod NUM_PORTS).
  - In that same cycle: pulse req_ready[g], latch addr/wdata/wmask/we into internal registers, set last_grant = g, load counter with READ_WAIT or WRITE_WAIT, go to ACCESS.
  - If no request is valid, stay in IDLE.
- ACCESS:
  - io_sram_* is driven from registered values only: en=1; re=!we; we=latched we; addr, din and wmask come from the latch.
  - Counter decrements each cycle. When it is 0: capture io_sram_dout into the rdata register (reads only), deassert all io_sram strobes on the next edge, go to RESP.
  - Duration is therefore WAIT+1 cycles.
- RESP: resp_valid[g]=1 for exactly one cycle; resp_rdata holds the captured data. Go to IDLE.
- Latency: accept at cycle T; SRAM active T+1..T+1+WAIT; resp_valid at T+2+WAIT. With WAIT=1, a read responds 3 cycles after accept.
- Throughput: one access per WAIT+3 cycles (IDLE, ACCESS, RESP). No back-to-back overlap.
- Write data: resp_rdata is left unchanged on writes.
- Requester contract: a requester holds req_* stable from req_valid assertion until req_ready. Dropping req_valid before grant is legal and loses nothing.
- Zero mask: a write with wmask=0 still runs the full sequence with io_sram_we=1 and wmask=0, and still produces resp_valid.
- NUM_PORTS=1: degenerates to a registered pass-through with the same timing.
- Simultaneous requests: exactly one grant per IDLE visit. Other ports stay pending with req_ready=0. A port that still asserts valid during RESP is not accepted until the following IDLE cycle.
- Reset mid-operation: the access is abandoned; all strobes drop in the cycle after reset is sampled; no resp_valid is issued. Requesters must reissue.
- Widths: the wait counter is 4 bits; the pointer is clog2(NUM_PORTS) bits, minimum 1, and wraps at NUM_PORTS-1 back to 0.

Optional Feature:
- Macro: SRAM_ARB_PORT0_PRIO_EN.
- Defined: port 0 (instruction fetch) has strict priority. When req_valid[0] is high in IDLE it is granted regardless of the pointer, and last_grant is not updated. Ports 1..N-1 round-robin among themselves.
- Undefined: pure round-robin across all ports, as described above.

Test Plan:
- Single read: after reset, port0 reads addr 0x00010 with SRAM model dout=0xDEADBEEF, READ_WAIT=1 -> req_ready[0] pulses at T; io_sram_en=1 and re=1 for 2 cycles; resp_valid[0] at T+3 with resp_rdata=0xDEADBEEF.
- Byte write: port1 writes addr 0x00004, wdata 0x11223344, wmask 4'b0010, WRITE_WAIT=2 -> io_sram_we=1 with wmask=0010 for 3 cycles; resp_valid[1] at T+4; model byte 1 = 0x33, other bytes untouched.
- Contention: both ports hold reads continuously for 4 accesses -> grants in order 0,1,0,1; no port gets two consecutive grants while the other waits.
- Reset during ACCESS: assert reset in the 2nd ACCESS cycle -> next cycle all io_sram_* are 0, no resp_valid is issued, and the next grant goes to port 0.
- Priority macro: with SRAM_ARB_PORT0_PRIO_EN defined, NUM_PORTS=3, all ports valid, port0 valid continuously -> port0 granted every time; after port0 drops, port1 then port2 are granted.
- Zero-wait back-to-back: READ_WAIT=0, port0 issues 3 reads -> each completes in 2 cycles after accept; accepts are spaced exactly 3 cycles apart.
